// File: rtl/lfo_channel_scheduler.sv
// lfo_channel_scheduler
//   Shares one sincos CORDIC core among CH_NUM LFO channels. Each channel has
//   its own phase accumulator. A sample tick snapshots every phase plus its
//   static offset. The snapshots are issued to the core one per cycle, and the
//   cosine results are collected in issue order. All channels are then
//   published together as unsigned modulator words.
//
// Ports
//   clk_i, srst_i       clock, synchronous active-high reset
//   sample_tick_i       starts a scheduling round (dropped + overrun_o if busy)
//   incr_en_i[c]        +1 step for channel c's phase accumulator
//   phase_offset_i      static offset, channel c at [c*AW +: AW]
//   core_valid_o/quadrant_o/angle_o   angle request to the shared core
//   core_valid_i/cos_i  signed cosine result, returned in issue order
//   modulator_o         unsigned modulator, channel c at [c*DW +: DW]
//   modulator_valid_o   one-cycle pulse when modulator_o is updated
//   busy_o              round in progress
//   overrun_o           one-cycle pulse after a dropped tick

// Per-channel phase accumulator; wraps modulo 2**AW.
module lfo_phase_acc #(
   parameter int AW = 11
) (
   input  logic          clk_i,
   input  logic          srst_i,
   input  logic          incr_en_i,
   output logic [AW-1:0] phase_o
);
   always_ff @(posedge clk_i) begin
      if (srst_i)         phase_o <= '0;
      else if (incr_en_i) phase_o <= phase_o + 1'b1;
   end
endmodule

module lfo_channel_scheduler #(
   parameter int CH_NUM = 4,
   parameter int AW     = 11,
   parameter int DW     = 9
) (
   input  logic                 clk_i,
   input  logic                 srst_i,
   input  logic                 sample_tick_i,
   input  logic [CH_NUM-1:0]    incr_en_i,
   input  logic [CH_NUM*AW-1:0] phase_offset_i,
   output logic                 core_valid_o,
   output logic [1:0]           core_quadrant_o,
   output logic [AW-3:0]        core_angle_o,
   input  logic                 core_valid_i,
   input  logic [DW-1:0]        core_cos_i,
   output logic [CH_NUM*DW-1:0] modulator_o,
   output logic                 modulator_valid_o,
   output logic                 busy_o,
   output logic                 overrun_o
);
   localparam int CW = $clog2(CH_NUM + 1);
   localparam int IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam logic [CW-1:0] CH_CNT  = CW'(CH_NUM);
   localparam logic [CW-1:0] CH_LAST = CW'(CH_NUM - 1);
   localparam logic [DW-1:0] MID     = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                       state;
   logic [CW-1:0]                issue_cnt, rx_cnt;
   logic [CH_NUM-1:0][AW-1:0]    phase, snap, shadow;
   logic [CH_NUM-1:0][DW-1:0]    stage, stage_nxt;
   logic [DW-1:0]                cos_u;
   logic                         capture, last_capture;

   // Per-channel accumulators and offset snapshots. The snapshot reads the
   // registered phase, so an increment in the tick cycle is not included.
   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      lfo_phase_acc #(.AW(AW)) u_acc (
         .clk_i     (clk_i),
         .srst_i    (srst_i),
         .incr_en_i (incr_en_i[c]),
         .phase_o   (phase[c])
      );
      assign snap[c] = phase[c] + phase_offset_i[c*AW +: AW];
   end

   // Signed two's complement to offset binary: flip the sign bit.
   assign cos_u        = {~core_cos_i[DW-1], core_cos_i[DW-2:0]};
   assign capture      = core_valid_i && (state != IDLE) && (rx_cnt < CH_CNT);
   assign last_capture = capture && (rx_cnt == CH_LAST);
   assign busy_o       = (state != IDLE);

   // Staging with this cycle's result merged in. Publishing from this lets
   // modulator_valid_o follow the last capture by a single cycle.
   always_comb begin
      stage_nxt = stage;
      if (capture) stage_nxt[rx_cnt[IW-1:0]] = cos_u;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state             <= IDLE;
         issue_cnt         <= '0;
         rx_cnt            <= '0;
         shadow            <= '0;
         stage             <= {CH_NUM{MID}};
         modulator_o       <= {CH_NUM{MID}};
         modulator_valid_o <= 1'b0;
         overrun_o         <= 1'b0;
         core_valid_o      <= 1'b0;
         core_quadrant_o   <= '0;
         core_angle_o      <= '0;
      end else begin
         modulator_valid_o <= 1'b0;
         overrun_o         <= 1'b0;
         stage             <= stage_nxt;
         if (capture) rx_cnt <= rx_cnt + 1'b1;
         if (last_capture) begin
            modulator_o       <= stage_nxt;
            modulator_valid_o <= 1'b1;
         end

         case (state)
            IDLE: begin
               core_valid_o <= 1'b0;
               if (sample_tick_i) begin
                  // Channel 0 goes out on the cycle right after the tick.
                  shadow                          <= snap;
                  {core_quadrant_o, core_angle_o} <= snap[0];
                  core_valid_o                    <= 1'b1;
                  issue_cnt                       <= CW'(1);
                  rx_cnt                          <= '0;
                  state                           <= ISSUE;
               end
            end
            ISSUE: begin
               if (sample_tick_i) overrun_o <= 1'b1;
               if (issue_cnt == CH_CNT) begin
                  core_valid_o <= 1'b0;
                  state        <= DRAIN;
               end else begin
                  {core_quadrant_o, core_angle_o} <= shadow[issue_cnt[IW-1:0]];
                  core_valid_o                    <= 1'b1;
                  issue_cnt                       <= issue_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (sample_tick_i) overrun_o <= 1'b1;
               if (rx_cnt == CH_CNT) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lfo_channel_scheduler.sv
module tb_lfo_channel_scheduler;
   localparam int CH = 4, AW = 11, DW = 9;
   localparam logic [CH*DW-1:0] MID4 = {9'h100, 9'h100, 9'h100, 9'h100};
   // Phases {0,512,1024,1536} -> cos {1,0,-1,0} -> {1FF,100,001,100}, ch0 in LSBs
   localparam logic [CH*DW-1:0] MODA = {9'h100, 9'h001, 9'h100, 9'h1FF};
   localparam logic [CH-1:0][AW-1:0] OFFS = {11'd1536, 11'd1024, 11'd512, 11'd0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 srst, tick, core_valid_o, core_valid_i;
   logic [CH-1:0]        incr_en;
   logic [CH*AW-1:0]     offs;
   logic [1:0]           quad;
   logic [AW-3:0]        angle;
   logic [DW-1:0]        core_cos;
   logic [CH*DW-1:0]     modulator;
   logic                 mod_valid, busy, overrun;

   lfo_channel_scheduler #(.CH_NUM(CH), .AW(AW), .DW(DW)) dut (
      .clk_i(clk), .srst_i(srst), .sample_tick_i(tick), .incr_en_i(incr_en),
      .phase_offset_i(offs), .core_valid_o(core_valid_o), .core_quadrant_o(quad),
      .core_angle_o(angle), .core_valid_i(core_valid_i), .core_cos_i(core_cos),
      .modulator_o(modulator), .modulator_valid_o(mod_valid), .busy_o(busy),
      .overrun_o(overrun));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nchk = 0, nerr = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Core model: ideal cosine scaled to +-255, optional pipeline latency.
   function automatic logic [DW-1:0] cos_model(input logic [AW-1:0] p);
      real r;
      r = $cos(6.283185307179586 * real'(p) / 2048.0) * 255.0;
      return 9'(int'(r));
   endfunction

   function automatic logic [CH*DW-1:0] exp_mod(input logic [CH-1:0][AW-1:0] ph);
      logic [CH*DW-1:0] m;
      logic [DW-1:0] s;
      m = '0;
      for (int c = 0; c < CH; c++) begin
         s = cos_model(ph[c]);
         m[c*DW +: DW] = {~s[DW-1], s[DW-2:0]};
      end
      return m;
   endfunction

   int lat = 0;
   logic [7:0]         cv_pipe = '0;
   logic [7:0][DW-1:0] cd_pipe = '0;
   always @(posedge clk) begin
      cv_pipe <= {cv_pipe[6:0], core_valid_o};
      cd_pipe <= {cd_pipe[6:0], cos_model({quad, angle})};
   end
   always_comb begin
      core_valid_i = core_valid_o;
      core_cos     = cos_model({quad, angle});
      if (lat != 0) begin
         core_valid_i = cv_pipe[lat-1];
         core_cos     = cd_pipe[lat-1];
      end
   end

   // Scoreboard queues
   typedef struct { int cyc; logic [AW-1:0] ph; } iss_t;
   typedef struct { int cyc; logic [CH*DW-1:0] mod; } mod_t;
   iss_t q_iss[$];
   mod_t q_mod[$];
   int   q_ovr[$];

   // Monitor
   always @(negedge clk) begin
      if (core_valid_o) begin
         if (q_iss.size() == 0) chk("unexpected_issue", 1, 0);
         else begin
            iss_t e;
            e = q_iss.pop_front();
            chk("issue_cycle", 64'(cyc), 64'(e.cyc));
            chk("issue_phase", {quad, angle}, e.ph);
         end
      end
      if (mod_valid) begin
         if (q_mod.size() == 0) chk("unexpected_mod_valid", 1, 0);
         else begin
            mod_t m;
            m = q_mod.pop_front();
            chk("mod_valid_cycle", 64'(cyc), 64'(m.cyc));
            chk("modulator", modulator, m.mod);
         end
      end
      if (overrun) begin
         if (q_ovr.size() == 0) chk("unexpected_overrun", 1, 0);
         else chk("overrun_cycle", 64'(cyc), 64'(q_ovr.pop_front()));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_round(input int t, input logic [CH-1:0][AW-1:0] ph,
                             input logic [CH*DW-1:0] m);
      for (int c = 0; c < CH; c++) q_iss.push_back('{t + 1 + c, ph[c]});
      q_mod.push_back('{t + CH + lat + 1, m});
   endtask

   task automatic round(input logic [CH-1:0][AW-1:0] ph, input logic [CH*DW-1:0] m);
      push_round(cyc, ph, m);
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("busy_rise", busy, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      chk("idle_reached", busy, 0);
      step(3);
   endtask

   initial begin
      int t;
      srst = 1'b1; tick = 1'b0; incr_en = '0; offs = OFFS;
      step(3);
      srst = 1'b0;
      step();
      chk("rst_modulator", modulator, MID4);
      chk("rst_mod_valid", mod_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_core_valid", core_valid_o, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_quad_angle", {quad, angle}, 0);
      step(5);
      chk("idle_modulator", modulator, MID4);

      // Quadrant sweep with a combinational core
      lat = 0;
      round({11'd1536, 11'd1024, 11'd512, 11'd0}, MODA);
      wait_idle();
      chk("mod_hold", modulator, MODA);

      // Core latency 3: valid pulse 8 cycles after the tick
      lat = 3;
      round({11'd1536, 11'd1024, 11'd512, 11'd0}, MODA);
      wait_idle();

      // ch0 wraps after 2048 steps; ch3 reaches 600, 600+1536 wraps to 88
      lat = 0;
      incr_en = 4'b1001;
      step(600);
      incr_en = 4'b0001;
      step(1448);
      incr_en = '0;
      step(2);
      round({11'd88, 11'd1024, 11'd512, 11'd0},
            exp_mod({11'd88, 11'd1024, 11'd512, 11'd0}));
      wait_idle();

      // Increment coincident with the tick: snapshot sees 2, phase becomes 3
      incr_en = 4'b0001;
      step(2);
      round({11'd88, 11'd1024, 11'd512, 11'd2},
            exp_mod({11'd88, 11'd1024, 11'd512, 11'd2}));
      incr_en = '0;
      wait_idle();

      // Second tick two cycles into a round is dropped
      t = cyc;
      push_round(t, {11'd88, 11'd1024, 11'd512, 11'd3},
                 exp_mod({11'd88, 11'd1024, 11'd512, 11'd3}));
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      tick = 1'b1;
      q_ovr.push_back(t + 3);
      step();
      tick = 1'b0;
      wait_idle();
      step(5);
      round({11'd88, 11'd1024, 11'd512, 11'd3},
            exp_mod({11'd88, 11'd1024, 11'd512, 11'd3}));
      wait_idle();

      // Reset mid-round: only ch0/ch1 get issued, no publish
      t = cyc;
      q_iss.push_back('{t + 1, 11'd3});
      q_iss.push_back('{t + 2, 11'd512});
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      srst = 1'b1;
      step();
      srst = 1'b0;
      chk("midrst_modulator", modulator, MID4);
      chk("midrst_busy", busy, 0);
      chk("midrst_core_valid", core_valid_o, 0);
      step(10);
      chk("midrst_no_publish", modulator, MID4);
      round({11'd1536, 11'd1024, 11'd512, 11'd0}, MODA);
      wait_idle();

      chk("issue_queue_empty", 64'(q_iss.size()), 0);
      chk("mod_queue_empty", 64'(q_mod.size()), 0);
      chk("ovr_queue_empty", 64'(q_ovr.size()), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/lfo_channel_scheduler.md
Name: lfo_channel_scheduler

Overview:
- Time-shares one sincos CORDIC core among CH_NUM independent LFO channels (e.g. stereo or multi-band tremolo) instead of instantiating one core per channel.
- Keeps one phase accumulator per channel, driven by that channel's frequency_control increment enable.
- On each sample tick, snapshots all phases and issues them to the shared core one per cycle, then collects the cosine results.
- Publishes all channels at once as unsigned modulator words with a single valid pulse.

Parameters:
- CH_NUM, 4, number of LFO channels; legal range 1..16.
- AW, 11, phase width including the 2 quadrant MSBs; core angle width is AW-2.
- DW, 9, signed result width from the core, and unsigned modulator width per channel.

Ports:
- clk_i  in  1  system clock.
- srst_i  in  1  synchronous reset, active-high.
- sample_tick_i  in  1  one-cycle audio sample strobe; starts a scheduling round.
- incr_en_i  in  CH_NUM  per-channel phase increment enable, one cycle per step.
- phase_offset_i  in  CH_NUM*AW  static per-channel phase offset; channel c occupies bits [c*AW +: AW].
- core_valid_o  out  1  angle request valid to the shared core.
- core_quadrant_o  out  2  angle[AW-1:AW-2] of the issued channel.
- core_angle_o  out  AW-2  angle[AW-3:0] of the issued channel.
- core_valid_i  in  1  result valid from the core, in issue order.
- core_cos_i  in  DW  signed cosine result from the core.
- modulator_o  out  CH_NUM*DW  unsigned per-channel modulator; channel c occupies bits [c*DW +: DW].
- modulator_valid_o  out  1  one-cycle pulse when modulator_o has been updated.
- busy_o  out  1  high while a round is in progress (state != IDLE).
- overrun_o  out  1  one-cycle pulse when a sample tick arrives while busy.

Behaviour:
- Reset values:
  - All phase accumulators 0; state IDLE.
  - Every modulator_o channel = 1 followed by DW-1 zeros (9'h100 at DW=9, mid-scale).
  - core_valid_o, modulator_valid_o, busy_o, overrun_o = 0; core_quadrant_o and core_angle_o = 0.
- Phase accumulators:
  - phase[c] <= phase[c]+1 on any cycle with incr_en_i[c]=1, in every state.
  - Wraps modulo 2**AW (all ones -> 0).
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: on sample_tick_i, copy every phase[c]+offset[c] (mod 2**AW) into shadow registers, using the registered phase value before any increment in the same cycle. Clear the issue and receive counters, go to ISSUE.
  - ISSUE: one channel per cycle, channel 0 first. core_valid_o=1 and quadrant/angle come from shadow[issue_cnt]. After channel CH_NUM-1 is issued, go to DRAIN.
  - DRAIN: wait until the receive counter reaches CH_NUM, then go to IDLE.
- Result capture, in ISSUE and DRAIN:
  - Each core_valid_i writes {~core_cos_i[DW-1], core_cos_i[DW-2:0]} into a staging register at index rx_cnt, then rx_cnt increments.
  - core_valid_i in IDLE is ignored.
  - Any core_valid_i beyond the CH_NUM-th in a round is ignored.
- Publish:
  - The cycle after the CH_NUM-th result is captured, all staging registers are copied to modulator_o together and modulator_valid_o pulses once.
  - modulator_o holds that value until the next publish.
- Latency, tick at cycle T:
  - Issues occupy T+1..T+CH_NUM.
  - With a core of latency L (L=0 for the unpipelined core), the last result arrives at T+CH_NUM+L.
  - modulator_valid_o asserts at T+CH_NUM+L+1.
- busy_o is high from T+1 until the state returns to IDLE.
- Overrun:
  - sample_tick_i while not IDLE is dropped and overrun_o pulses the next cycle.
  - The round in progress is unaffected.
- Reset mid-round: the round is abandoned, staging contents are discarded, no modulator_valid_o pulse occurs, and modulator_o returns to mid-scale.
- Arithmetic: the offset add is an unsigned AW-bit sum and the carry is dropped.
- CH_NUM=1: ISSUE lasts exactly one cycle.

Test Plan:
- Reset, then no activity: modulator_o = 4 x 9'h100, modulator_valid_o=0, busy_o=0, core_valid_o=0.
- All phases 0, offsets {0,512,1024,1536}, one tick, combinational cosine model:
  - Issued quadrants 0,1,2,3 with angle 0 on 4 consecutive cycles.
  - modulator_o ~ {9'h1FF, 9'h100, 9'h001, 9'h100} (+-1 LSB).
  - modulator_valid_o 5 cycles after the tick.
- Model core latency 3: valid pulse exactly 8 cycles after the tick; results land in channel order 0..3.
- incr_en_i[0] held high for 2048 cycles: phase[0] wraps back to 0. incr_en_i[0] coincident with the tick: the snapshot uses the pre-increment phase.
- Second tick 2 cycles after the first:
  - overrun_o pulses once.
  - Exactly one modulator_valid_o for the first round.
  - The next tick after IDLE is accepted normally.
- srst_i asserted at T+2 of a round: no valid pulse, modulator_o = mid-scale, and the next tick completes a normal round.
